branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Consumer end of the 32-bit comparator interface: takes the EQ/LT/GT flags from COMPARATOR_32bits plus operand sign bits and decides RV32I conditional branches (BEQ/BNE/BLT/BGE/BLTU/BGEU).
- Issues a PC redirect to fetch over a valid/ready handshake, then holds a pipeline flush for a fixed number of cycles.
- Sits in the execute stage between the comparator and the fetch/PC logic.

Parameters:
- XLEN, 32, datapath width of pc, imm and redirect_pc.
- FLUSH_CYCLES, 2, cycles flush stays high after the redirect is accepted (0 allowed, meaning no flush).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  branch request valid.
- req_ready  out  1  unit can accept a request.
- funct3  in  3  branch funct3 field.
- pc  in  XLEN  PC of the branch instruction.
- imm  in  XLEN  B-type immediate, already sign-extended.
- a_msb  in  1  bit 31 of rs1.
- b_msb  in  1  bit 31 of rs2.
- eq  in  1  comparator EQ, unsigned.
- lt  in  1  comparator LT, unsigned.
- gt  in  1  comparator GT, unsigned.
- resolve_valid  out  1  one-cycle pulse: decision available.
- resolve_taken  out  1  decision; qualified by resolve_valid.
- illegal  out  1  one-cycle pulse: funct3 is 010 or 011.
- flag_err  out  1  one-cycle pulse: {eq,lt,gt} not one-hot.
- misalign  out  1  one-cycle pulse: taken target[1:0] != 0.
- redirect_valid  out  1  redirect request to fetch.
- redirect_ready  in  1  fetch accepts the redirect.
- redirect_pc  out  XLEN  branch target.
- flush  out  1  squash younger instructions.
- taken_count  out  32  taken branches; see Optional Feature.
- not_taken_count  out  32  not-taken branches; see Optional Feature.

Behaviour:
- Reset: rst is synchronous and active-high; clock port clk. At the edge with rst=1:
  - state returns to IDLE from any state.
  - All outputs go to 0 except req_ready=1. redirect_pc=0. Counters=0.
  - A pending redirect is dropped with no flush.
  - rst overrides any simultaneous handshake.
- State machine: IDLE -> RESOLVE -> (REDIRECT -> FLUSH) -> IDLE.
- IDLE:
  - req_ready=1; all other handshake outputs 0.
  - On req_valid=1, register funct3, pc, imm, a_msb, b_msb, eq, lt, gt, then go to RESOLVE.
- RESOLVE (exactly one cycle):
  - resolve_valid=1.
  - slt = (a_msb != b_msb) ? a_msb : lt.
  - Taken condition by funct3: 000 eq; 001 !eq; 100 slt; 101 !slt; 110 lt; 111 !lt.
  - funct3 010/011: illegal=1, taken=0.
  - Flags not one-hot: flag_err=1, taken=0. This takes priority over funct3 decoding; illegal is still reported for 010/011.
  - target = pc + imm, modulo 2^XLEN, wrap-around allowed.
  - If taken and target[1:0] != 0: misalign=1, resolve_taken=0, next state IDLE.
  - If taken and aligned: next state REDIRECT.
  - Otherwise: next state IDLE.
- REDIRECT:
  - redirect_valid=1; redirect_pc=target, held stable until accepted.
  - req_ready=0.
  - On redirect_ready=1: load flush counter with FLUSH_CYCLES, go to FLUSH. If FLUSH_CYCLES=0, go directly to IDLE.
- FLUSH:
  - flush=1; counter decrements each cycle.
  - When the counter reaches 1 at an edge, go to IDLE.
  - flush lasts exactly FLUSH_CYCLES cycles.
- Latency, request accepted at edge N:
  - resolve_valid in cycle N+1.
  - Earliest redirect_valid in cycle N+2.
  - Earliest flush in cycle N+3.
- Throughput:
  - Not-taken branch: one per 2 cycles.
  - Taken branch: 2 + handshake wait + FLUSH_CYCLES + 1 cycles.
- Input sampling: inputs are sampled only at the accept edge; later changes have no effect.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- Defined:
  - taken_count increments on each RESOLVE cycle with resolve_taken=1.
  - not_taken_count increments on each other RESOLVE cycle, including illegal, flag_err and misalign.
  - Both counters are 32-bit, wrap from FFFFFFFF to 0, and clear on rst.
- Undefined: both ports remain present, tied to 0; no counter registers are built.

Test Plan:
- BEQ taken path: funct3=000, eq=1, pc=00001000, imm=00000010, FLUSH_CYCLES=2, redirect_ready=1.
  - Required: resolve_taken=1 at N+1; redirect_pc=00001010 at N+2; flush high for exactly 2 cycles; req_ready=1 again afterwards.
- Signed compare via sign bits: BLT with lt=0, gt=1, a_msb=1, b_msb=0 (A=FFFFFFFF, B=00000001).
  - Required: taken. The same flags with BLTU -> not taken, back to IDLE at N+2.
- Redirect backpressure then reset: redirect_ready=0 for 5 cycles.
  - Required: redirect_valid and redirect_pc stable throughout.
  - Then rst=1 for 1 cycle: redirect_valid=0, flush never asserts, req_ready=1.
- Error cases:
  - funct3=011 -> illegal pulse, not taken.
  - eq=1, lt=1 -> flag_err pulse, not taken.
  - BNE taken with imm=00000002 -> misalign pulse, no redirect_valid.
- Wrap-around: BGEU taken, pc=FFFFFFF0, imm=00000020.
  - Required: redirect_pc=00000010.
- Stats (BRANCH_STATS_EN defined): 3 taken + 4 not-taken branches.
  - Required: taken_count=3, not_taken_count=4.
  - Without the macro: both read 0.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolver: decides RV32I conditional branches from comparator flags,
// redirects fetch over valid/ready, then holds flush. Optional counters via BRANCH_STATS_EN.
module branch_resolve_unit #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic            a_msb,
  input  logic            b_msb,
  input  logic            eq,
  input  logic            lt,
  input  logic            gt,
  output logic            resolve_valid,
  output logic            resolve_taken,
  output logic            illegal,
  output logic            flag_err,
  output logic            misalign,
  output logic            redirect_valid,
  input  logic            redirect_ready,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  output logic [31:0]     taken_count,
  output logic [31:0]     not_taken_count
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] RESOLVE  = 2'd1;
  localparam logic [1:0] REDIRECT = 2'd2;
  localparam logic [1:0] FLUSH    = 2'd3;

  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;

  logic [1:0]      state_reg, state_next;
  logic [2:0]      funct3_reg;
  logic [XLEN-1:0] pc_reg, imm_reg;
  logic            a_msb_reg, b_msb_reg;
  logic            eq_reg, lt_reg, gt_reg;
  logic [XLEN-1:0] redirect_pc_reg;
  logic [CW-1:0]   flush_cnt_reg;

  logic            flags_onehot, funct3_illegal, slt, cond, base_taken, target_misaligned, taken_ok;
  logic [XLEN-1:0] target;

  always_comb begin
    flags_onehot   = ({eq_reg, lt_reg, gt_reg} == 3'b100) ||
                     ({eq_reg, lt_reg, gt_reg} == 3'b010) ||
                     ({eq_reg, lt_reg, gt_reg} == 3'b001);
    funct3_illegal = (funct3_reg == 3'b010) || (funct3_reg == 3'b011);
    // Differing sign bits decide signed order directly; otherwise unsigned order holds.
    slt            = (a_msb_reg != b_msb_reg) ? a_msb_reg : lt_reg;
    cond           = 1'b0;
    case (funct3_reg)
      3'b000:  cond = eq_reg;
      3'b001:  cond = !eq_reg;
      3'b100:  cond = slt;
      3'b101:  cond = !slt;
      3'b110:  cond = lt_reg;
      3'b111:  cond = !lt_reg;
      default: cond = 1'b0;
    endcase
    base_taken        = flags_onehot && cond;
    target            = pc_reg + imm_reg;
    target_misaligned = base_taken && (target[1:0] != 2'b00);
    taken_ok          = base_taken && !target_misaligned;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (req_valid) state_next = RESOLVE;
      RESOLVE:  state_next = taken_ok ? REDIRECT : IDLE;
      REDIRECT: if (redirect_ready) state_next = (FLUSH_CYCLES == 0) ? IDLE : FLUSH;
      FLUSH:    if (flush_cnt_reg <= CW'(1)) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      funct3_reg      <= '0;
      pc_reg          <= '0;
      imm_reg         <= '0;
      a_msb_reg       <= 1'b0;
      b_msb_reg       <= 1'b0;
      eq_reg          <= 1'b0;
      lt_reg          <= 1'b0;
      gt_reg          <= 1'b0;
      redirect_pc_reg <= '0;
      flush_cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && req_valid) begin
        funct3_reg <= funct3;
        pc_reg     <= pc;
        imm_reg    <= imm;
        a_msb_reg  <= a_msb;
        b_msb_reg  <= b_msb;
        eq_reg     <= eq;
        lt_reg     <= lt;
        gt_reg     <= gt;
      end
      if (state_reg == RESOLVE && taken_ok) redirect_pc_reg <= target;
      if (state_reg == REDIRECT && redirect_ready) flush_cnt_reg <= CW'(FLUSH_CYCLES);
      else if (state_reg == FLUSH) flush_cnt_reg <= flush_cnt_reg - CW'(1);
    end
  end

  assign req_ready      = (state_reg == IDLE);
  assign resolve_valid  = (state_reg == RESOLVE);
  assign resolve_taken  = resolve_valid && taken_ok;
  assign illegal        = resolve_valid && funct3_illegal;
  assign flag_err       = resolve_valid && !flags_onehot;
  assign misalign       = resolve_valid && target_misaligned;
  assign redirect_valid = (state_reg == REDIRECT);
  assign redirect_pc    = redirect_pc_reg;
  assign flush          = (state_reg == FLUSH);

`ifdef BRANCH_STATS_EN
  logic [31:0] taken_count_reg, not_taken_count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      taken_count_reg     <= '0;
      not_taken_count_reg <= '0;
    end else if (resolve_valid) begin
      if (resolve_taken) taken_count_reg <= taken_count_reg + 32'd1;
      else               not_taken_count_reg <= not_taken_count_reg + 32'd1;
    end
  end

  assign taken_count     = taken_count_reg;
  assign not_taken_count = not_taken_count_reg;
`else
  assign taken_count     = '0;
  assign not_taken_count = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: driver pushes reference-model results, monitor pops and compares.
module tb_branch_resolve_unit;
  localparam int FC = 2;

  logic        clk = 0, rst = 1;
  logic        req_valid = 0, req_ready;
  logic [2:0]  funct3 = 0;
  logic [31:0] pc = 0, imm = 0;
  logic        a_msb = 0, b_msb = 0, eq = 0, lt = 0, gt = 0;
  logic        resolve_valid, resolve_taken, illegal, flag_err, misalign;
  logic        redirect_valid, redirect_ready = 1;
  logic [31:0] redirect_pc, taken_count, not_taken_count;
  logic        flush;

  branch_resolve_unit #(.XLEN(32), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .funct3(funct3), .pc(pc), .imm(imm), .a_msb(a_msb), .b_msb(b_msb),
    .eq(eq), .lt(lt), .gt(gt), .resolve_valid(resolve_valid),
    .resolve_taken(resolve_taken), .illegal(illegal), .flag_err(flag_err),
    .misalign(misalign), .redirect_valid(redirect_valid),
    .redirect_ready(redirect_ready), .redirect_pc(redirect_pc), .flush(flush),
    .taken_count(taken_count), .not_taken_count(not_taken_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic taken, ill, ferr, mis;
  } exp_t;

  exp_t        res_q[$];
  logic [31:0] redir_q[$];
  int          checks = 0, passes = 0;
  int          m_taken = 0, m_not_taken = 0;
  bit          rr_rand = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: signed/unsigned order from the operand values themselves.
  function automatic exp_t model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                 input bit flags_ok, input logic [31:0] target);
    exp_t e;
    bit c;
    case (f3)
      3'd0: c = (a == b);
      3'd1: c = (a != b);
      3'd4: c = ($signed(a) < $signed(b));
      3'd5: c = ($signed(a) >= $signed(b));
      3'd6: c = (a < b);
      3'd7: c = (a >= b);
      default: c = 0;
    endcase
    c      = c && flags_ok;
    e.ill  = (f3 == 3'd2) || (f3 == 3'd3);
    e.ferr = !flags_ok;
    e.mis  = c && (target[1:0] != 2'b00);
    e.taken = c && !e.mis;
    return e;
  endfunction

  // Issue one branch; force_flags replaces comparator flags with bad_flags.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] p, input logic [31:0] im,
                       input bit force_flags, input logic [2:0] bad_flags);
    logic [2:0]  fl;
    logic [31:0] tgt;
    exp_t        e;
    int          n = 0;
    while (1) begin
      @(negedge clk);
      if (req_ready) break;
      if (++n > 300) begin chk("req_ready_timeout", 0, 1); return; end
    end
    fl  = force_flags ? bad_flags : {a == b, a < b, a > b};
    tgt = p + im;
    e   = model(f3, a, b, !force_flags, tgt);
    res_q.push_back(e);
    if (e.taken) begin redir_q.push_back(tgt); m_taken++; end
    else m_not_taken++;
    req_valid = 1; funct3 = f3; pc = p; imm = im;
    a_msb = a[31]; b_msb = b[31]; {eq, lt, gt} = fl;
    @(posedge clk); #1;
    req_valid = 0; funct3 = 3'($urandom); pc = $urandom; imm = $urandom;
    {a_msb, b_msb, eq, lt, gt} = 5'($urandom);
    @(negedge clk);
    chk("lat_resolve_valid", {31'd0, resolve_valid}, 1);
    @(negedge clk);
    chk("lat_redirect_valid", {31'd0, redirect_valid}, {31'd0, e.taken});
    if (!e.taken) chk("back_idle_req_ready", {31'd0, req_ready}, 1);
  endtask

  task automatic drain();
    int n = 0;
    while (1) begin
      @(negedge clk);
      if (req_ready && res_q.size() == 0 && redir_q.size() == 0 && !flush) break;
      if (++n > 300) begin chk("drain_timeout", 0, 1); return; end
    end
    repeat (FC + 2) @(negedge clk);
  endtask

  task automatic chk_stats(input string tag);
`ifdef BRANCH_STATS_EN
    chk({tag, "_taken_count"}, taken_count, m_taken);
    chk({tag, "_not_taken_count"}, not_taken_count, m_not_taken);
`else
    chk({tag, "_taken_count"}, taken_count, 0);
    chk({tag, "_not_taken_count"}, not_taken_count, 0);
`endif
  endtask

  // Redirect-ready randomizer, driven just after the active edge.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rr_rand) redirect_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: compares decisions, redirect targets, flush length and redirect hold.
  initial begin
    int          flush_left = 0;
    bit          expect_idle = 0, was_stalled = 0;
    logic [31:0] held_pc = 0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst) begin flush_left = 0; expect_idle = 0; was_stalled = 0; continue; end
      if (flush_left > 0) begin
        chk("flush_high", {31'd0, flush}, 1);
        flush_left--;
      end else if (expect_idle) begin
        chk("flush_end_idle", {30'd0, flush, req_ready}, 32'd1);
        expect_idle = 0;
      end else if (flush) chk("unexpected_flush", {31'd0, flush}, 0);
      if (resolve_valid) begin
        if (res_q.size() == 0) chk("resolve_unexpected", 1, 0);
        else begin
          e = res_q.pop_front();
          chk($sformatf("resolve{taken,ill,ferr,mis} f3=%0d", dut.funct3_reg),
              {28'd0, resolve_taken, illegal, flag_err, misalign}, {28'd0, e});
        end
      end
      if (was_stalled && redirect_valid) chk("redirect_pc_hold", redirect_pc, held_pc);
      was_stalled = redirect_valid && !redirect_ready;
      held_pc     = redirect_pc;
      if (redirect_valid && redirect_ready) begin
        if (redir_q.size() == 0) chk("redirect_unexpected", 1, 0);
        else chk("redirect_pc", redirect_pc, redir_q.pop_front());
        flush_left  = FC;
        expect_idle = 1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [2:0]  bad [5];
    logic [31:0] a, b, p, im, pc0;
    bad[0] = 3'b000; bad[1] = 3'b011; bad[2] = 3'b101; bad[3] = 3'b110; bad[4] = 3'b111;

    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset_req_ready", {31'd0, req_ready}, 1);
    chk("reset_outs", {26'd0, resolve_valid, resolve_taken, illegal, flag_err, redirect_valid, flush}, 0);
    chk("reset_redirect_pc", redirect_pc, 0);
    chk("reset_counts", taken_count | not_taken_count, 0);

    redirect_ready = 1;
    issue(3'b000, 32'h5, 32'h5, 32'h0000_1000, 32'h0000_0010, 0, 0);   // BEQ taken
    chk("beq_redirect_pc", redirect_pc, 32'h0000_1010);
    issue(3'b100, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h40, 0, 0);       // BLT signed taken
    issue(3'b110, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h40, 0, 0);       // BLTU not taken
    issue(3'b011, 32'h3, 32'h9, 32'h200, 32'h8, 0, 0);                // illegal
    issue(3'b000, 32'h3, 32'h3, 32'h200, 32'h8, 1, 3'b110);           // eq&lt flag_err
    issue(3'b001, 32'h1, 32'h2, 32'h300, 32'h2, 0, 0);                // BNE misaligned
    issue(3'b111, 32'h9, 32'h2, 32'hFFFF_FFF0, 32'h20, 0, 0);         // BGEU wrap
    chk("wrap_redirect_pc", redirect_pc, 32'h0000_0010);
    drain();

    // Backpressure then reset drops the redirect.
    redirect_ready = 0;
    issue(3'b000, 32'h7, 32'h7, 32'h4000, 32'h100, 0, 0);
    pc0 = redirect_pc;
    chk("bp_redirect_pc", pc0, 32'h4100);
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold_valid", {31'd0, redirect_valid}, 1);
      chk("bp_hold_pc", redirect_pc, pc0);
    end
    rst = 1;
    @(posedge clk); #1 rst = 0;
    redir_q.delete();
    m_taken = 0; m_not_taken = 0;
    @(negedge clk);
    chk("rst_redirect_valid", {31'd0, redirect_valid}, 0);
    chk("rst_req_ready", {31'd0, req_ready}, 1);
    repeat (4) begin @(negedge clk); chk("rst_no_flush", {31'd0, flush}, 0); end
    redirect_ready = 1;

    // Stats: 3 taken + 4 not-taken.
    issue(3'b000, 32'h1, 32'h1, 32'h10, 32'h10, 0, 0);
    issue(3'b101, 32'h1, 32'hFFFF_FFFF, 32'h10, 32'h20, 0, 0);
    issue(3'b111, 32'h8, 32'h2, 32'h10, 32'h30, 0, 0);
    issue(3'b001, 32'h1, 32'h1, 32'h10, 32'h10, 0, 0);
    issue(3'b010, 32'h1, 32'h2, 32'h10, 32'h10, 0, 0);
    issue(3'b000, 32'h1, 32'h1, 32'h10, 32'h10, 1, 3'b111);
    issue(3'b001, 32'h1, 32'h2, 32'h10, 32'h6, 0, 0);
    drain();
    chk_stats("stats7");

    rr_rand = 1;
    for (int i = 0; i < 150; i++) begin
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : 32'($urandom);
      if ($urandom_range(0, 3) == 0) b[31] = ~a[31];
      p  = $urandom & 32'hFFFF_FFFC;
      im = $urandom & 32'hFFFF_FFFE;
      if ($urandom_range(0, 3) != 0) im[1] = 1'b0;
      issue(3'($urandom), a, b, p, im, $urandom_range(0, 9) == 0, bad[$urandom_range(0, 4)]);
    end
    rr_rand = 0; redirect_ready = 1;
    drain();
    chk_stats("random");
    chk("queues_empty", res_q.size() + redir_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
